// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read port, redirect input and downstream instruction handshake.
interface fetch_unit_if #(parameter int XLEN = 32);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            exec_enable_n;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr, instr_pc, exec_enable_n
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr, instr_pc, exec_enable_n
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited imem reads, in-order instruction buffer, redirect flush.
// Latency is memory latency + 1; requests stop when buffer + in-flight reach FIFO_DEPTH, head holds under instr_ready=0.
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] fifo_dat [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc  [FIFO_DEPTH];
    logic [XLEN-1:0] side_pc  [FIFO_DEPTH];
    logic [AW-1:0]   f_wr, f_rd, s_wr, s_rd;
    logic [CW-1:0]   count, outstanding, drop, credits;
    logic            accept, rsp, push, pop, valid;

    assign credits = CW'(FIFO_DEPTH) - count - outstanding;
    assign valid   = (count != '0);
    assign accept  = bus.imem_req && bus.imem_ready;
    assign rsp     = bus.imem_rvalid && (outstanding != '0);
    // A response landing in the redirect cycle belongs to the old stream.
    assign push    = rsp && (drop == '0) && !bus.redirect;
    assign pop     = valid && bus.instr_ready;

    assign bus.imem_req      = (state == FETCH) && (credits != '0) && !bus.redirect;
    assign bus.imem_addr     = pc;
    assign bus.instr_valid   = valid;
    assign bus.instr         = valid ? fifo_dat[f_rd] : '0;
    assign bus.instr_pc      = valid ? fifo_pc[f_rd]  : '0;
    assign bus.exec_enable_n = ~valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            f_wr        <= '0;
            f_rd        <= '0;
            s_wr        <= '0;
            s_rd        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            case (state)
                IDLE:    state <= FETCH;
                FETCH:   if (credits == '0) state <= STALL;
                STALL:   if (credits != '0) state <= FETCH;
                default: state <= IDLE;
            endcase

            if (bus.redirect)
                pc <= bus.redirect_pc & ~XLEN'(3);
            else if (accept)
                pc <= pc + XLEN'(4);

            if (accept)
                s_wr <= s_wr + AW'(1);
            if (rsp)
                s_rd <= s_rd + AW'(1);
            outstanding <= outstanding + CW'(accept) - CW'(rsp);

            if (bus.redirect)
                drop <= outstanding - CW'(rsp);
            else if (rsp && (drop != '0))
                drop <= drop - CW'(1);

            if (bus.redirect) begin
                f_wr  <= '0;
                f_rd  <= '0;
                count <= '0;
            end else begin
                if (push)
                    f_wr <= f_wr + AW'(1);
                if (pop)
                    f_rd <= f_rd + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (accept)
            side_pc[s_wr] <= pc;
        if (push) begin
            fifo_dat[f_wr] <= bus.imem_rdata;
            fifo_pc[f_wr]  <= side_pc[s_rd];
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a simple in-order instruction memory model.
module tb_fetch_unit;
    logic clk;
    logic rst;
    logic mem_hold;
    int   n_chk;
    int   n_pass;

    logic [31:0] mq      [$];
    logic [31:0] acc_log [$];
    logic [63:0] pop_log [$];

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return ((a >> 2) + 32'd1) * 32'h11;
    endfunction

    // Memory answers one cycle after accept unless held; logs accepts and pops.
    always @(posedge clk) begin : mem_model
        logic [31:0] a;
        if (rst) begin
            mq.delete();
            bus.imem_rvalid <= 1'b0;
            bus.imem_rdata  <= 32'h0;
        end else begin
            if (bus.imem_req && bus.imem_ready) begin
                mq.push_back(bus.imem_addr);
                acc_log.push_back(bus.imem_addr);
            end
            if (bus.instr_valid && bus.instr_ready)
                pop_log.push_back({bus.instr_pc, bus.instr});
            if (!mem_hold && mq.size() > 0) begin
                a = mq.pop_front();
                bus.imem_rvalid <= 1'b1;
                bus.imem_rdata  <= word_at(a);
            end else begin
                bus.imem_rvalid <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic chk_pop(input string tag, input int i, input logic [31:0] ei, input logic [31:0] ep);
        logic [63:0] e;
        if (i < pop_log.size()) begin
            e = pop_log[i];
            check({tag, "_instr"}, e[31:0], ei);
            check({tag, "_pc"}, e[63:32], ep);
        end else begin
            check({tag, "_missing"}, 32'(pop_log.size()), 32'(i + 1));
        end
    endtask

    task automatic chk_acc(input string tag, input int i, input logic [31:0] ea);
        if (i < acc_log.size())
            check({tag, "_addr"}, acc_log[i], ea);
        else
            check({tag, "_missing"}, 32'(acc_log.size()), 32'(i + 1));
    endtask

    task automatic wait_pops(input string tag, input int n, input int budget);
        int k = 0;
        while (pop_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_npops"}, 32'(pop_log.size()), 32'(n));
    endtask

    task automatic do_reset(input string tag);
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.instr_ready = 1'b0;
        mem_hold        = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_req"},    32'(bus.imem_req), 32'd0);
        check({tag, "_addr"},   bus.imem_addr, 32'h0);
        check({tag, "_valid"},  32'(bus.instr_valid), 32'd0);
        check({tag, "_instr"},  bus.instr, 32'h0);
        check({tag, "_ipc"},    bus.instr_pc, 32'h0);
        check({tag, "_en_n"},   32'(bus.exec_enable_n), 32'd1);
        rst = 1'b0;
        acc_log.delete();
        pop_log.delete();
        @(negedge clk);
        check({tag, "_first_req"},  32'(bus.imem_req), 32'd1);
        check({tag, "_first_addr"}, bus.imem_addr, 32'h0);
        check({tag, "_first_en_n"}, 32'(bus.exec_enable_n), 32'd1);
    endtask

    initial begin
        n_chk           = 0;
        n_pass          = 0;
        rst             = 1'b1;
        mem_hold        = 1'b0;
        bus.imem_ready  = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.instr_ready = 1'b0;

        // Streaming with an always-ready consumer
        do_reset("rst0");
        bus.instr_ready = 1'b1;
        wait_pops("stream", 3, 40);
        chk_pop("s0", 0, 32'h11, 32'h0);
        chk_pop("s1", 1, 32'h22, 32'h4);
        chk_pop("s2", 2, 32'h33, 32'h8);

        // Backpressure: two credits, then one pop frees exactly one request
        do_reset("rst1");
        repeat (10) @(negedge clk);
        check("bp_acc_n", 32'(acc_log.size()), 32'd2);
        chk_acc("bp_a0", 0, 32'h0);
        chk_acc("bp_a1", 1, 32'h4);
        check("bp_req", 32'(bus.imem_req), 32'd0);
        check("bp_valid", 32'(bus.instr_valid), 32'd1);
        check("bp_en_n", 32'(bus.exec_enable_n), 32'd0);
        check("bp_head", bus.instr, 32'h11);
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        repeat (8) @(negedge clk);
        check("bp_acc_n2", 32'(acc_log.size()), 32'd3);
        chk_acc("bp_a2", 2, 32'h8);
        check("bp_req2", 32'(bus.imem_req), 32'd0);
        check("bp_head2", bus.instr, 32'h22);
        check("bp_pc2", bus.instr_pc, 32'h4);

        // Redirect with two requests still outstanding
        do_reset("rst2");
        mem_hold = 1'b1;
        repeat (6) @(negedge clk);
        check("rd_acc_n", 32'(acc_log.size()), 32'd2);
        check("rd_req", 32'(bus.imem_req), 32'd0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        @(negedge clk);
        bus.redirect = 1'b0;
        check("rd_flush_valid", 32'(bus.instr_valid), 32'd0);
        check("rd_addr", bus.imem_addr, 32'h100);
        acc_log.delete();
        pop_log.delete();
        mem_hold        = 1'b0;
        bus.instr_ready = 1'b1;
        wait_pops("rd", 1, 40);
        chk_pop("rd_p0", 0, 32'h451, 32'h100);
        chk_acc("rd_a0", 0, 32'h100);

        // Unaligned redirect target, then PC wrap at the top of memory
        do_reset("rst3");
        bus.instr_ready = 1'b1;
        repeat (5) @(negedge clk);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h103;
        #1;
        check("r103_req_low", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        bus.redirect = 1'b0;
        check("r103_addr", bus.imem_addr, 32'h100);
        acc_log.delete();
        pop_log.delete();
        wait_pops("r103", 2, 40);
        chk_pop("r103_p0", 0, 32'h451, 32'h100);
        chk_pop("r103_p1", 1, 32'h462, 32'h104);
        chk_acc("r103_a0", 0, 32'h100);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        bus.redirect = 1'b0;
        acc_log.delete();
        pop_log.delete();
        wait_pops("wrap", 2, 40);
        chk_pop("wrap_p0", 0, 32'h4000_0000, 32'hFFFF_FFFC);
        chk_pop("wrap_p1", 1, 32'h11, 32'h0);
        chk_acc("wrap_a1", 1, 32'h0);

        // Redirect coinciding with a pop and a returning response
        do_reset("rst4");
        repeat (8) @(negedge clk);
        check("sim_full_head", bus.instr, 32'h11);
        mem_hold        = 1'b1;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("sim_acc_n", 32'(acc_log.size()), 32'd3);
        mem_hold = 1'b0;
        @(negedge clk);
        check("sim_rvalid", 32'(bus.imem_rvalid), 32'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.redirect = 1'b0;
        check("sim_flush", 32'(bus.instr_valid), 32'd0);
        check("sim_npops", 32'(pop_log.size()), 32'd2);
        chk_pop("sim_head", 1, 32'h22, 32'h4);
        acc_log.delete();
        pop_log.delete();
        wait_pops("sim", 1, 40);
        chk_pop("sim_next", 0, 32'h891, 32'h200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
